// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arp_pkg
// Brief    : Shared ARP constants, field bundle and FSM encoding (TX and RX).
// Revision : 1.0
// ============================================================================
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'd6;
    localparam logic [7:0]  ARP_PLEN       = 8'd4;
    localparam logic [15:0] ARP_OP_REQ     = 16'd1;
    localparam logic [15:0] ARP_OP_REP     = 16'd2;
    localparam int          ARP_NWORDS     = 7;

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_SEND = 1'b1;

    // Field order matches wire order, so the 224-bit bundle is the payload.
    typedef struct packed {
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
    } arp_fields_t;

endpackage
`default_nettype wire

// File: rtl/arp_word_sel.sv
`default_nettype none
// ============================================================================
// Module   : arp_word_sel
// Brief    : Combinational selector of one 32-bit big-endian ARP payload word.
// Revision : 1.0
// ============================================================================
module arp_word_sel
    import arp_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  arp_fields_t      fields_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [31:0]      word_o
);

    always_comb begin
        word_o = 32'h0;
        case (cnt_i)
            CNT_W'(0): word_o = {fields_i.htype, fields_i.ptype};
            CNT_W'(1): word_o = {fields_i.hlen, fields_i.plen, fields_i.oper};
            CNT_W'(2): word_o = fields_i.sha[47:16];
            CNT_W'(3): word_o = {fields_i.sha[15:0], fields_i.spa[31:16]};
            CNT_W'(4): word_o = {fields_i.spa[15:0], fields_i.tha[47:32]};
            CNT_W'(5): word_o = fields_i.tha[31:0];
            CNT_W'(6): word_o = fields_i.tpa;
            default:   word_o = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/arp_tx.sv
`default_nettype none
// ============================================================================
// Module   : arp_tx
// Brief    : Latches one ARP field set and streams it as seven 32-bit words.
// Revision : 1.0
// ============================================================================
module arp_tx
    import arp_pkg::*;
#(
    parameter int NWORDS = ARP_NWORDS,
    parameter int CNT_W  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] hdr_type,
    input  logic [15:0] proto_type,
    input  logic [7:0]  hdr_addr_length,
    input  logic [7:0]  pro_addr_length,
    input  logic [15:0] operation,
    input  logic [47:0] send_hdr_addr,
    input  logic [31:0] send_ip_addr,
    input  logic [47:0] target_hdr_addr,
    input  logic [31:0] target_ip_addr,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        tx_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    arp_fields_t      fields_q, fields_d;
    logic [31:0]      out_word_q, word_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             tx_done_q, tx_done_d;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign tx_done   = tx_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fields_d    = fields_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        tx_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (in_valid) begin
                    fields_d    = {hdr_type, proto_type, hdr_addr_length, pro_addr_length,
                                   operation, send_hdr_addr, send_ip_addr,
                                   target_hdr_addr, target_ip_addr};
                    cnt_d       = '0;
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        tx_done_d   = 1'b1;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        out_last_d = (cnt_q + CNT_W'(1)) == LAST_IDX;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The output word is registered from next-state fields/counter so word0 appears right after accept.
    arp_word_sel #(.CNT_W(CNT_W)) u_word_sel (
        .fields_i (fields_d),
        .cnt_i    (cnt_d),
        .word_o   (word_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fields_q    <= '0;
            out_word_q  <= 32'h0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fields_q    <= fields_d;
            out_word_q  <= word_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tx_done_q   <= tx_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_tx
// Brief    : Scoreboard bench for arp_tx.
// Revision : 1.0
// ============================================================================
module tb_arp_tx;
    import arp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] hdr_type = '0, proto_type = '0, operation = '0;
    logic [7:0]  hdr_addr_length = '0, pro_addr_length = '0;
    logic [47:0] send_hdr_addr = '0, target_hdr_addr = '0;
    logic [31:0] send_ip_addr = '0, target_ip_addr = '0;
    logic [31:0] out_word;
    logic        out_valid, out_last, tx_done;
    logic        out_ready;

    always #5 clk = ~clk;

    arp_tx dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .hdr_type(hdr_type), .proto_type(proto_type),
        .hdr_addr_length(hdr_addr_length), .pro_addr_length(pro_addr_length),
        .operation(operation), .send_hdr_addr(send_hdr_addr), .send_ip_addr(send_ip_addr),
        .target_hdr_addr(target_hdr_addr), .target_ip_addr(target_ip_addr),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .tx_done(tx_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [32:0] sb[$];
    logic [31:0] got_q[$];
    int          beats = 0;
    int          cyc = 0;
    logic        exp_done = 1'b0;
    logic        stall_pend = 1'b0;
    logic [32:0] prev;
    logic        rdy_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_model();
        logic [223:0] v;
        v = {hdr_type, proto_type, hdr_addr_length, pro_addr_length, operation,
             send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr};
        for (int k = 0; k < 7; k++) sb.push_back({1'(k == 6), v[223-32*k -: 32]});
    endfunction

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            exp_done   = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_hold", 64'({out_last, out_word}), 64'(prev));
                check("valid_hold", 64'(out_valid), 64'(1));
            end
            check("tx_done", 64'(tx_done), 64'(exp_done));
            exp_done = 1'b0;
            if (out_valid) check("rdy_in_send", 64'(in_ready), 64'(0));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 64'(out_word), 64'hDEAD);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check("word", 64'({out_last, out_word}), 64'(e));
                    if (e[32]) exp_done = 1'b1;
                end
                got_q.push_back(out_word);
                beats++;
                stall_pend = 1'b0;
            end else if (out_valid) begin
                stall_pend = 1'b1;
                prev = {out_last, out_word};
            end else begin
                stall_pend = 1'b0;
            end
            if (in_valid && in_ready) push_model();
        end
    end

    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                out_ready = 1'b1;
                ph = 0;
            end
        end
    end

    task automatic set_fields(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                              input logic [47:0] tha, input logic [31:0] tpa);
        hdr_type = ARP_HTYPE_ETH;  proto_type = ARP_PTYPE_IPV4;
        hdr_addr_length = ARP_HLEN; pro_addr_length = ARP_PLEN;
        operation = op; send_hdr_addr = sha; send_ip_addr = spa;
        target_hdr_addr = tha; target_ip_addr = tpa;
    endtask

    task automatic wait_done(input int n);
        bit seen = 0;
        for (int i = 0; i < n && !seen; i++) begin
            @(negedge clk);
            if (tx_done) seen = 1;
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        logic [31:0] req_words [7];
        int acc;
        int b0;
        req_words = '{32'h00010800, 32'h06040001, 32'h00112233, 32'h4455C0A8,
                      32'h00010000, 32'h00000000, 32'hC0A80002};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out", 64'({out_valid, out_last, tx_done, out_word}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(in_ready), 64'(1));

        // Request packet, out_ready held high
        got_q.delete();
        set_fields(ARP_OP_REQ, 48'h001122334455, 32'hC0A80001, 48'h0, 32'hC0A80002);
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        acc = cyc;
        wait_done(40);
        check("lat", 64'(cyc - acc), 64'(7));
        check("req_len", 64'(got_q.size()), 64'(7));
        for (int i = 0; i < 7 && i < got_q.size(); i++) check("req_word", 64'(got_q[i]), 64'(req_words[i]));

        // Same packet with a stalling sink
        got_q.delete();
        rdy_mode = 1'b1;
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done(80);
        rdy_mode = 1'b0;
        check("stall_len", 64'(got_q.size()), 64'(7));
        for (int i = 0; i < 7 && i < got_q.size(); i++) check("stall_word", 64'(got_q[i]), 64'(req_words[i]));

        // in_valid held across two packets; inputs change mid-SEND
        got_q.delete();
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1;
        set_fields(ARP_OP_REP, 48'hA1A2A3A4A5A6, 32'h0A000001, 48'h001122334455, 32'hC0A80001);
        wait_done(40);
        check("bubble_rdy", 64'(in_ready), 64'(1));
        check("bubble_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("bubble_next", 64'(out_valid), 64'(1));
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done(40);
        check("b2b_len", 64'(got_q.size()), 64'(14));
        if (got_q.size() == 14) begin
            check("pkt1_word1", 64'(got_q[1]), 64'(32'h06040001));
            check("pkt2_word1", 64'(got_q[8]), 64'(32'h06040002));
            check("pkt2_word2", 64'(got_q[9]), 64'(32'hA1A2A3A4));
        end

        // Reset after the third beat aborts the packet
        b0 = beats;
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        begin
            bit hit = 0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(posedge clk);
                if (beats - b0 >= 3) hit = 1;
            end
            if (!hit) check("beat_timeout", 64'(0), 64'(1));
        end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("abort_out", 64'({out_valid, out_last, tx_done, out_word}), 64'(0));
        check("abort_rdy", 64'(in_ready), 64'(1));
        got_q.delete();
        set_fields(ARP_OP_REQ, 48'h001122334455, 32'hC0A80001, 48'h0, 32'hC0A80002);
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        wait_done(40);
        check("fresh_len", 64'(got_q.size()), 64'(7));
        if (got_q.size() > 0) check("fresh_word0", 64'(got_q[0]), 64'(32'h00010800));

        // rst and in_valid together
        @(posedge clk); #1 begin rst = 1'b1; in_valid = 1'b1; end
        @(negedge clk);
        check("rst_rdy_low", 64'(in_ready), 64'(0));
        @(posedge clk); #1 begin rst = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        check("rst_no_accept", 64'(out_valid), 64'(0));
        check("rst_rdy_high", 64'(in_ready), 64'(1));
        repeat (3) @(negedge clk);
        check("idle_valid", 64'(out_valid), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
